// File: rtl/attn_pkg.sv
// Shared types and helpers for the attention/matmul result path.
package attn_pkg;

  localparam int unsigned SRAM_ADDR_RANGE = 16;
  localparam int unsigned SRAM_DATA_WIDTH = 32;
  localparam int unsigned DIM_W           = SRAM_DATA_WIDTH / 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHeader = 2'd1,
    StStream = 2'd2,
    StDone   = 2'd3
  } e_wr_state_t;

  // Header word layout shared with the input/weight SRAM word 0.
  function automatic logic [2*DIM_W-1:0] pack_dims(input logic [DIM_W-1:0] rows,
                                                    input logic [DIM_W-1:0] cols);
    return {rows, cols};
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO buffering result words between the MAC stream and the SRAM write port.
module result_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW:0] PtrOne = {{IdxW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty.
  logic [IdxW:0]     wptr_q, wptr_d;
  logic [IdxW:0]     rptr_q, rptr_d;
  logic              do_push, do_pop;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[IdxW] != rptr_q[IdxW]) &&
                     (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]);
  assign head_data = mem_q[rptr_q[IdxW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PtrOne;
    if (do_pop)  rptr_d = rptr_q + PtrOne;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push) mem_q[wptr_q[IdxW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/result_write_ctrl.sv
// Streams result words through a FIFO into sequential result SRAM addresses from a base.
// Optional RESULT_WRITE_HEADER_EN: first writes a {rows, cols} header word at the base.
module result_write_ctrl
  import attn_pkg::*;
#(
  parameter int unsigned DATA_W     = SRAM_DATA_WIDTH,
  parameter int unsigned ADDR_W     = SRAM_ADDR_RANGE,
  parameter int unsigned DIM_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  output logic              busy,
  output logic              done,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  output logic              dut__tb__sram_result_write_enable,
  output logic [ADDR_W-1:0] dut__tb__sram_result_write_address,
  output logic [DATA_W-1:0] dut__tb__sram_result_write_data
);

  localparam int unsigned CntW = 2 * DIM_W;
  localparam logic [CntW-1:0] CntOne = {{(CntW-1){1'b0}}, 1'b1};
`ifdef RESULT_WRITE_HEADER_EN
  localparam logic [ADDR_W-1:0] HdrOff = {{(ADDR_W-1){1'b0}}, 1'b1};
`else
  localparam logic [ADDR_W-1:0] HdrOff = '0;
`endif

  e_wr_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CntW-1:0]   total_q, total_d;
  logic [CntW-1:0]   accepted_q, accepted_d;
  logic [CntW-1:0]   written_q, written_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef RESULT_WRITE_HEADER_EN
  logic [DIM_W-1:0]  rows_q, rows_d;
  logic [DIM_W-1:0]  cols_q, cols_d;
`endif

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  // Ready depends only on registered state, never on res_valid.
  assign res_ready = (state_q == StStream) && !fifo_full && (accepted_q < total_q);
  assign fifo_push = res_valid && res_ready;
  assign fifo_pop  = (state_q == StStream) && !fifo_empty;

  assign busy = (state_q == StHeader) || (state_q == StStream);
  assign done = (state_q == StDone);

  assign dut__tb__sram_result_write_enable  = we_q;
  assign dut__tb__sram_result_write_address = waddr_q;
  assign dut__tb__sram_result_write_data    = wdata_q;

  result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (res_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (fifo_head)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    total_d    = total_q;
    accepted_d = accepted_q;
    written_d  = written_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
`ifdef RESULT_WRITE_HEADER_EN
    rows_d     = rows_q;
    cols_d     = cols_q;
`endif

    if (fifo_push) accepted_d = accepted_q + CntOne;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d     = base_addr;
          total_d    = CntW'(rows) * CntW'(cols);
          accepted_d = '0;
          written_d  = '0;
`ifdef RESULT_WRITE_HEADER_EN
          rows_d     = rows;
          cols_d     = cols;
          state_d    = StHeader;
`else
          state_d    = StStream;
`endif
        end
      end
`ifdef RESULT_WRITE_HEADER_EN
      StHeader: begin
        we_d    = 1'b1;
        waddr_d = base_q;
        wdata_d = DATA_W'(pack_dims(rows_q, cols_q));
        state_d = StStream;
      end
`endif
      StStream: begin
        if (fifo_pop) begin
          we_d      = 1'b1;
          waddr_d   = base_q + HdrOff + written_q[ADDR_W-1:0];
          wdata_d   = fifo_head;
          written_d = written_q + CntOne;
        end else if (written_q == total_q) begin
          // Nothing buffered and every word written out.
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      base_q     <= '0;
      total_q    <= '0;
      accepted_q <= '0;
      written_q  <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
`ifdef RESULT_WRITE_HEADER_EN
      rows_q     <= '0;
      cols_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      total_q    <= total_d;
      accepted_q <= accepted_d;
      written_q  <= written_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
`ifdef RESULT_WRITE_HEADER_EN
      rows_q     <= rows_d;
      cols_q     <= cols_d;
`endif
    end
  end

endmodule

// File: tb/tb_result_write_ctrl.sv
// Self-checking bench for result_write_ctrl: vector table plus reset/restart sequences.
module tb_result_write_ctrl;

`ifdef RESULT_WRITE_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] rows = '0;
  logic [15:0] cols = '0;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic        busy, done, res_ready, we;
  logic [15:0] waddr;
  logic [31:0] wdata;

  always #5 clk = ~clk;

  result_write_ctrl #(
    .DATA_W     (32),
    .ADDR_W     (16),
    .DIM_W      (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk                                (clk),
    .reset                              (reset),
    .start                              (start),
    .base_addr                          (base_addr),
    .rows                               (rows),
    .cols                               (cols),
    .busy                               (busy),
    .done                               (done),
    .res_valid                          (res_valid),
    .res_data                           (res_data),
    .res_ready                          (res_ready),
    .dut__tb__sram_result_write_enable  (we),
    .dut__tb__sram_result_write_address (waddr),
    .dut__tb__sram_result_write_data    (wdata)
  );

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          stamp;
  } exp_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] rows;
    logic [15:0] cols;
    int          nwords;
    bit          gap;
    bit          inject;
    int          exp_taken;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_writes = 0;
  bit   prev_we = 1'b0;
  bit   done_after_we = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write-port monitor: every write must match the oldest scoreboard entry, 2 edges after accept.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (we) begin
        n_writes++;
        if (sb_q.size() == 0) begin
          chk("write_expected", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr", 64'(waddr), 64'(e.addr));
          chk("wr_data", 64'(wdata), 64'(e.data));
          chk("wr_latency", 64'(cyc), 64'(e.stamp));
        end
      end
      if (done) chk("done_after_write", 64'(prev_we), 64'(done_after_we));
    end
    prev_we = we;
  end

  task automatic run_case(input int v);
    vec_t t;
    int   i;
    int   start_cyc;
    bit   seen_done;
    bit   pend;
    bit   injected;
    t = vecs[v];
    i = 0;
    seen_done = 1'b0;
    pend = 1'b0;
    injected = 1'b0;
    n_writes = 0;
    done_after_we = (t.exp_taken + HDR) > 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = t.base;
    rows = t.rows;
    cols = t.cols;
    start_cyc = cyc;
    if (HDR != 0) sb_q.push_back('{t.base, {t.rows, t.cols}, cyc + 2});
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int k = 0; k < 400 && !seen_done; k++) begin
      start = 1'b0;
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (t.inject && i == 2 && !injected) begin
          start = 1'b1;
          base_addr = 16'h0900;
          rows = 16'd0;
          cols = 16'd0;
          injected = 1'b1;
        end
        if (i < t.nwords) begin
          if (!pend && t.gap && $urandom_range(0, 2) == 0) begin
            res_valid = 1'b0;
          end else begin
            res_valid = 1'b1;
            res_data = (32'(v) << 16) | 32'(i + 1);
          end
        end else begin
          res_valid = 1'b0;
        end
        if (res_valid && res_ready) begin
          sb_q.push_back('{16'(t.base + 16'(HDR) + 16'(i)), res_data, cyc + 2});
          i++;
          pend = 1'b0;
        end else begin
          pend = res_valid;
        end
        @(negedge clk);
      end
    end
    res_valid = 1'b0;
    start = 1'b0;
    chk("done_seen", 64'(seen_done), 64'd1);
    chk("ready_at_done", 64'(res_ready), 64'd0);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("words_taken", 64'(i), 64'(t.exp_taken));
    if (t.rows == 16'd0 || t.cols == 16'd0)
      chk("zero_done_latency", 64'(cyc - start_cyc), 64'(2 + HDR));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    chk("write_count", 64'(n_writes), 64'(t.exp_taken + HDR));
  endtask

  initial begin
    int i;
    vecs[0] = '{16'h0010, 16'd2, 16'd3, 6, 1'b0, 1'b0, 6};
    vecs[1] = '{16'hFFFE, 16'd1, 16'd4, 4, 1'b1, 1'b0, 4};
    vecs[2] = '{16'h0100, 16'd3, 16'd3, 10, 1'b0, 1'b0, 9};
    vecs[3] = '{16'h0200, 16'd0, 16'd5, 2, 1'b0, 1'b0, 0};
    vecs[4] = '{16'h0300, 16'd2, 16'd2, 4, 1'b0, 1'b1, 4};
    vecs[5] = '{16'h0400, 16'd4, 16'd5, 20, 1'b1, 1'b0, 20};

    @(negedge clk);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_addr", 64'(waddr), 64'd0);
    chk("rst_data", 64'(wdata), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(res_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) run_case(v);

    // Reset in the middle of a run: outputs clear at once, no stale words afterwards.
    @(negedge clk);
    start = 1'b1;
    base_addr = 16'h0600;
    rows = 16'd2;
    cols = 16'd3;
    done_after_we = 1'b1;
    if (HDR != 0) sb_q.push_back('{16'h0600, 32'h0002_0003, cyc + 2});
    @(negedge clk);
    start = 1'b0;
    i = 0;
    for (int k = 0; k < 50 && i < 3; k++) begin
      res_valid = 1'b1;
      res_data = 32'hA0 + 32'(i);
      if (res_ready) begin
        sb_q.push_back('{16'(16'h0600 + 16'(HDR) + 16'(i)), res_data, cyc + 2});
        i++;
      end
      @(negedge clk);
    end
    res_valid = 1'b0;
    chk("mid_words_taken", 64'(i), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("arst_we", 64'(we), 64'd0);
    chk("arst_addr", 64'(waddr), 64'd0);
    chk("arst_data", 64'(wdata), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(res_ready), 64'd0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_done", 64'(done), 64'd0);
      chk("post_rst_we", 64'(we), 64'd0);
    end

    run_case(0);

    repeat (3) @(negedge clk);
    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
